// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and helpers
// for the multi-cycle logic/shift unit.
package alu_pkg;

  localparam logic [3:0] OP_NOR  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_A    = 4'b0101;
  localparam logic [3:0] OP_ZERO = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// alu_logic_core: combinational 3-bit logic-code table.
// op[2]=0 selects XOR/NOR by op[0] alone.
module alu_logic_core #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_code,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    if (!i_code[2]) begin
      o_y = i_code[0] ? (i_a ^ i_b) : ~(i_a | i_b);
    end else begin
      unique case (i_code[1:0])
        2'b00: o_y = i_a & i_b;
        2'b01: o_y = i_a;
        2'b10: o_y = '0;
        2'b11: o_y = i_a | i_b;
      endcase
    end
  end

endmodule

// File: rtl/alu_logic_shift_mc.sv
// alu_logic_shift_mc: multi-cycle logic/shift unit for the EX stage.
// The iterative shifter moves the accumulator at most STEP bits per cycle.
module alu_logic_shift_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [SHW-1:0] STEP_M1 = SHW'(STEP - 1);

  state_t           r_state;
  state_t           w_nstate;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_res_d;
  logic [SHW-1:0]   r_rem;
  logic [SHW-1:0]   w_k;
  logic [SHW-1:0]   w_rem_next;
  logic [1:0]       r_kind;
  logic             r_zero;
  logic             w_accept;
  logic             w_direct;
  logic             w_last;
  logic             w_res_load;

  alu_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_code(op[2:0]),
    .i_a   (a),
    .i_b   (b),
    .o_y   (w_logic)
  );

  assign w_accept   = in_valid & in_ready;
  assign w_direct   = ~op[3] | (shamt == '0);
  assign w_k        = (r_rem > STEP_M1) ? STEP_M1 + SHW'(1) : r_rem;
  assign w_rem_next = r_rem - w_k;
  assign w_last     = (w_rem_next == '0);

  // Mux of constant shifts; k never exceeds STEP.
  always_comb begin
    w_shifted = r_acc;
    for (int j = 1; j <= STEP; j++) begin
      if (int'(w_k) == j) begin
        if (r_kind == 2'b11)
          w_shifted = $unsigned($signed(r_acc) >>> j);
        else if (r_kind == 2'b00)
          w_shifted = r_acc << j;
        else
          w_shifted = r_acc >> j;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_nstate = w_direct ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) w_nstate = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)       w_nstate = w_direct ? ST_DONE : ST_SHIFT;
        else if (out_ready) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      ST_IDLE:  in_ready = 1'b1;
      ST_SHIFT: busy = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_res_load = 1'b0;
    w_res_d    = w_shifted;
    if (w_accept) begin
      w_res_load = w_direct;
      w_res_d    = op[3] ? a : w_logic;
    end else if (r_state == ST_SHIFT) begin
      w_res_load = w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_rem    <= '0;
      r_kind   <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      if (w_accept && !w_direct) begin
        r_acc  <= a;
        r_rem  <= shamt;
        r_kind <= op[1:0];
      end else if (r_state == ST_SHIFT) begin
        r_acc <= w_shifted;
        r_rem <= w_rem_next;
      end
      if (w_res_load) begin
        r_result <= w_res_d;
        r_zero   <= (w_res_d == '0);
      end
    end
  end

  assign result = r_result;
  assign zero   = r_zero;

endmodule
